// File: rtl/mem_rd_seq_pkg.sv
// Shared decode definitions for the memory-read sequencer: size codes, FSM states,
// default line geometry and the size-to-byte-count helper.
package mem_rd_seq_pkg;

   localparam int unsigned LINE_LOG2_DEF = 4;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_WORD  = 2'b01;
   localparam logic [1:0] SZ_DWORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD1  = 2'b01,
      RD2  = 2'b10,
      DONE = 2'b11
   } state_t;

   // Reserved size code 2'b11 reads as a dword.
   function automatic logic [2:0] size_nbytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_WORD: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_rd_seq_line_byte_extract.sv
// Pulls up to four consecutive bytes out of a cache line, right-justified, with
// the lanes at and above the requested count forced to zero.
module line_byte_extract
   import mem_rd_seq_pkg::*;
#(
   parameter int unsigned LINE_LOG2 = LINE_LOG2_DEF
) (
   input  logic [(8<<LINE_LOG2)-1:0] line,
   input  logic [LINE_LOG2-1:0]      start,
   input  logic [2:0]                count,
   output logic [31:0]               bytes
);

   localparam int unsigned LINE_BYTES = 1 << LINE_LOG2;

   logic [7:0] lane [LINE_BYTES];

   always_comb begin
      for (int i = 0; i < LINE_BYTES; i++) begin
         lane[i] = line[8*i +: 8];
      end
   end

   always_comb begin
      bytes = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < count) begin
            bytes[8*i +: 8] = lane[LINE_LOG2'(start + LINE_LOG2'(i))];
         end
      end
   end

endmodule

// File: rtl/mem_rd_seq.sv
// Memory-read sequencer: turns one sized read request into one or two cache line
// reads and assembles a right-justified, zero-extended 32-bit operand.
module mem_rd_seq
   import mem_rd_seq_pkg::*;
#(
   parameter int unsigned LINE_LOG2 = LINE_LOG2_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_addr,
   input  logic [1:0]                req_size,
   output logic                      dc_req,
   output logic [31:0]               dc_addr,
   input  logic                      dc_ack,
   input  logic [(8<<LINE_LOG2)-1:0] dc_rdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_data,
   output logic                      out_split
);

   localparam int unsigned LINE_BYTES = 1 << LINE_LOG2;
   localparam int unsigned CNT_W      = LINE_LOG2 + 1;
   localparam logic [31:0] LINE_MASK  = ~(32'(LINE_BYTES) - 32'd1);

   state_t               state, state_nx;
   logic [LINE_LOG2-1:0] off_q;
   logic [2:0]           nbytes_q;
   logic                 split_q;

   logic [2:0]           req_nbytes;
   logic                 req_split;
   logic [2:0]           cnt1, cnt2;
   logic [31:0]          ext1, ext2;
   logic                 accept;
   logic [31:0]          data_nx;
   logic [31:0]          dc_addr_nx;
   logic                 split_nx;

   assign req_nbytes = size_nbytes(req_size);
   assign req_split  = (CNT_W'(req_addr[LINE_LOG2-1:0]) + CNT_W'(req_nbytes))
                       > CNT_W'(LINE_BYTES);

   // First read supplies bytes up to the end of the line; the second supplies the rest.
   assign cnt1 = split_q ? 3'(CNT_W'(LINE_BYTES) - CNT_W'(off_q)) : nbytes_q;
   assign cnt2 = nbytes_q - cnt1;

   line_byte_extract #(.LINE_LOG2(LINE_LOG2)) u_ext_first (
      .line  (dc_rdata),
      .start (off_q),
      .count (cnt1),
      .bytes (ext1)
   );

   line_byte_extract #(.LINE_LOG2(LINE_LOG2)) u_ext_second (
      .line  (dc_rdata),
      .start (LINE_LOG2'(0)),
      .count (cnt2),
      .bytes (ext2)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and next register values; flush overrides everything else.
   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      data_nx    = out_data;
      split_nx   = out_split;
      dc_addr_nx = dc_addr;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_nx   = RD1;
               data_nx    = '0;
               split_nx   = 1'b0;
               dc_addr_nx = req_addr & LINE_MASK;
            end
         end
         RD1: begin
            if (dc_ack) begin
               data_nx = ext1;
               if (split_q) begin
                  state_nx   = RD2;
                  dc_addr_nx = dc_addr + 32'(LINE_BYTES);
               end else begin
                  state_nx = DONE;
               end
            end
         end
         RD2: begin
            if (dc_ack) begin
               data_nx  = out_data | (ext2 << {cnt1, 3'b000});
               split_nx = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx   = IDLE;
         accept     = 1'b0;
         data_nx    = out_data;
         split_nx   = out_split;
         dc_addr_nx = dc_addr;
      end
   end

   // Handshake outputs are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b1;
         dc_req    <= 1'b0;
         dc_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_split <= 1'b0;
         off_q     <= '0;
         nbytes_q  <= '0;
         split_q   <= 1'b0;
      end else begin
         req_ready <= (state_nx == IDLE);
         dc_req    <= (state_nx == RD1) || (state_nx == RD2);
         out_valid <= (state_nx == DONE);
         dc_addr   <= dc_addr_nx;
         out_data  <= data_nx;
         out_split <= split_nx;
         if (accept) begin
            off_q    <= req_addr[LINE_LOG2-1:0];
            nbytes_q <= req_nbytes;
            split_q  <= req_split;
         end
      end
   end

endmodule

// File: tb/tb_mem_rd_seq.sv
// Bench for mem_rd_seq: table vectors, corner sequences and randomized requests
// checked against a byte-addressed memory model.
module tb_mem_rd_seq;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic [1:0]   req_size;
   logic         dc_req;
   logic [31:0]  dc_addr;
   logic         dc_ack;
   logic [127:0] dc_rdata;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         out_split;

   mem_rd_seq dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .dc_req    (dc_req),
      .dc_addr   (dc_addr),
      .dc_ack    (dc_ack),
      .dc_rdata  (dc_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_split (out_split)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;

   logic [7:0]  salt;
   int          ack_lat;
   bit          rand_lat;
   int          ack_limit;
   int          acks;
   bit          junk_ack;
   logic [31:0] addr_log [$];

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      int          lat;
      logic [31:0] data;
      logic        split;
      logic [31:0] a0;
      logic [31:0] a1;
      int          nrd;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory byte at linear address a.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ salt;
   endfunction

   function automatic logic [127:0] mk_line(input logic [31:0] la);
      logic [127:0] l;
      for (int j = 0; j < 16; j++) l[8*j +: 8] = mem_byte(la + 32'(j));
      return l;
   endfunction

   function automatic int nb_of(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < nb_of(sz); i++) r = r | (32'(mem_byte(a + 32'(i))) << (8*i));
      return r;
   endfunction

   // Cache responder: acks after ack_lat waiting cycles, logs each acked line address.
   initial begin
      int          wait_cnt;
      logic [31:0] held;
      wait_cnt = 0;
      held     = '0;
      dc_ack   = 1'b0;
      dc_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         dc_ack = 1'b0;
         if (dc_req) begin
            if (wait_cnt == 0) held = dc_addr;
            else chk("dc_addr_stable", dc_addr, held);
            if (wait_cnt >= ack_lat && acks < ack_limit) begin
               dc_ack   = 1'b1;
               dc_rdata = mk_line(dc_addr);
               addr_log.push_back(dc_addr);
               acks++;
               wait_cnt = 0;
               if (rand_lat) ack_lat = $urandom_range(0, 3);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            if (junk_ack) begin
               dc_ack   = 1'b1;
               dc_rdata = '1;
            end
         end
      end
   end

   task automatic start_req(input logic [31:0] a, input logic [1:0] sz);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_addr  = a;
      req_size  = sz;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("dc_req_after_accept", 32'(dc_req), 32'd1);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("out_valid_arrives", 32'(out_valid), 32'd1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_ready", 32'(out_valid), 32'd0);
      chk("req_ready_after_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input int exp_lat,
                          input logic [31:0] ed, input logic es, input logic [31:0] ea0,
                          input logic [31:0] ea1, input int enrd, input int stall);
      int n;
      addr_log.delete();
      start_req(a, sz);
      wait_out(n);
      if (exp_lat >= 0) chk("latency", 32'(n), 32'(exp_lat));
      chk("out_data", out_data, ed);
      chk("out_split", 32'(out_split), 32'(es));
      chk("n_line_reads", 32'(addr_log.size()), 32'(enrd));
      if (addr_log.size() > 0) chk("first_line_addr", addr_log[0], ea0);
      if (enrd == 2 && addr_log.size() > 1) chk("second_line_addr", addr_log[1], ea1);
      chk("req_ready_in_done", 32'(req_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         chk("out_valid_held", 32'(out_valid), 32'd1);
         chk("out_data_held", out_data, ed);
      end
      release_out();
   endtask

   initial begin
      int          n;
      logic [31:0] a;
      logic [1:0]  sz;
      int          nb;
      logic [31:0] a0;
      vectors     = 0;
      miscompares = 0;
      salt        = 8'h00;
      ack_lat     = 0;
      rand_lat    = 1'b0;
      ack_limit   = 1000000;
      acks        = 0;
      junk_ack    = 1'b0;
      rst         = 1'b1;
      flush       = 1'b0;
      req_valid   = 1'b0;
      req_addr    = '0;
      req_size    = '0;
      out_ready   = 1'b0;

      tbl[0] = '{32'h0000_1000, 2'b10, 2, 32'h0302_0100, 1'b0, 32'h0000_1000, 32'h0, 1};
      tbl[1] = '{32'h0000_100F, 2'b00, 1, 32'h0000_000F, 1'b0, 32'h0000_1000, 32'h0, 1};
      tbl[2] = '{32'h0000_100E, 2'b10, 0, 32'h1110_0F0E, 1'b1, 32'h0000_1000, 32'h0000_1010, 2};
      tbl[3] = '{32'hFFFF_FFFF, 2'b01, 1, 32'h0000_00FF, 1'b1, 32'hFFFF_FFF0, 32'h0000_0000, 2};
      tbl[4] = '{32'h0000_100D, 2'b11, 0, 32'h100F_0E0D, 1'b1, 32'h0000_1000, 32'h0000_1010, 2};
      tbl[5] = '{32'h0000_100C, 2'b10, 0, 32'h0F0E_0D0C, 1'b0, 32'h0000_1000, 32'h0, 1};
      tbl[6] = '{32'h0000_200F, 2'b01, 3, 32'h0000_100F, 1'b1, 32'h0000_2000, 32'h0000_2010, 2};
      tbl[7] = '{32'h0000_300E, 2'b01, 0, 32'h0000_0F0E, 1'b0, 32'h0000_3000, 32'h0, 1};
      tbl[8] = '{32'h0000_4003, 2'b00, 1, 32'h0000_0003, 1'b0, 32'h0000_4000, 32'h0, 1};
      tbl[9] = '{32'h0000_5005, 2'b01, 2, 32'h0000_0605, 1'b0, 32'h0000_5000, 32'h0, 1};

      // Reset state: IDLE, so req_ready is high and everything else is zero.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_dc_req", 32'(dc_req), 32'd0);
      chk("rst_dc_addr", dc_addr, 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_split", 32'(out_split), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 10; v++) begin
         ack_lat = tbl[v].lat;
         run_txn(tbl[v].addr, tbl[v].size, (tbl[v].lat + 1) * tbl[v].nrd, tbl[v].data,
                 tbl[v].split, tbl[v].a0, tbl[v].a1, tbl[v].nrd, v % 3);
      end

      // Flush while the second line read is outstanding.
      ack_lat   = 0;
      ack_limit = acks + 1;
      start_req(32'h0000_100E, 2'b10);
      n = 0;
      while (!(dc_req && dc_addr == 32'h0000_1010) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reach_second_read", dc_addr, 32'h0000_1010);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_dc_req", 32'(dc_req), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_req_ready", 32'(req_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("flush_no_out_valid", 32'(out_valid), 32'd0);
      ack_limit = 1000000;
      run_txn(32'h0000_100E, 2'b10, 2, 32'h1110_0F0E, 1'b1, 32'h0000_1000, 32'h0000_1010, 2, 0);

      // Flush in DONE drops out_valid even with out_ready high.
      start_req(32'h0000_6001, 2'b01);
      wait_out(n);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      chk("flush_done_out_valid", 32'(out_valid), 32'd0);
      chk("flush_done_req_ready", 32'(req_ready), 32'd1);

      // Back-pressure with a waiting request and stray cache acks.
      start_req(32'h0000_1000, 2'b10);
      wait_out(n);
      chk("bp_data", out_data, 32'h0302_0100);
      req_valid = 1'b1;
      req_addr  = 32'h0000_2004;
      req_size  = 2'b01;
      junk_ack  = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data", out_data, 32'h0302_0100);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_dc_req", 32'(dc_req), 32'd0);
      end
      junk_ack  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_no_turnaround", 32'(dc_req), 32'd0);
      chk("bp_req_ready_idle", 32'(req_ready), 32'd1);
      chk("bp_out_valid_low", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp_accept_late", 32'(dc_req), 32'd1);
      wait_out(n);
      chk("bp_next_data", out_data, 32'h0000_0504);
      release_out();

      // Asynchronous reset mid-read.
      ack_limit = acks;
      start_req(32'h0000_7008, 2'b10);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dc_req", 32'(dc_req), 32'd0);
      chk("arst_dc_addr", dc_addr, 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      ack_limit = 1000000;
      @(posedge clk);
      #1;

      // Randomized requests against the memory model.
      salt     = 8'($urandom);
      rand_lat = 1'b1;
      ack_lat  = $urandom_range(0, 3);
      for (int r = 0; r < 40; r++) begin
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[3:0] = 4'($urandom_range(12, 15));
         sz = 2'($urandom_range(0, 3));
         nb = nb_of(sz);
         a0 = a & 32'hFFFF_FFF0;
         run_txn(a, sz, -1, model_data(a, sz), (32'(a[3:0]) + 32'(nb)) > 32'd16,
                 a0, a0 + 32'd16, ((32'(a[3:0]) + 32'(nb)) > 32'd16) ? 2 : 1,
                 $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
